// File: rtl/branch_predictor_pht.sv
// branch_predictor_pht: PHT of saturating counters with registered prediction and index tag-back.
// Define BP_GSHARE_EN to XOR the global history into the index (gshare); otherwise bimodal.
module branch_predictor_pht #(
   parameter int PC_W  = 32,
   parameter int IDX_W = 6,
   parameter int CTR_W = 2,
   parameter int GHR_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lookup_valid,
   input  logic [PC_W-1:0]  lookup_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   input  logic             ghr_clr,
   output logic [GHR_W-1:0] ghr
);
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   logic [CTR_W-1:0] ctr [0:(1<<IDX_W)-1];
   logic [CTR_W-1:0] cur, nxt;
   logic [IDX_W-1:0] idx;
   logic             unused_bits;
`ifdef BP_GSHARE_EN
   logic [GHR_W-1:0] ghr_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) ghr_q <= '0;
      else if (ghr_clr) ghr_q <= '0;
      else if (upd_valid) ghr_q <= (ghr_q << 1) | GHR_W'(upd_taken);
   assign idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign ghr = ghr_q;
   assign unused_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};
`else
   assign idx = lookup_pc[IDX_W+1:2];
   assign ghr = '0;
   assign unused_bits = ^{ghr_clr, lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};
`endif
   always_comb begin
      cur = ctr[upd_idx];
      nxt = upd_taken ? ((&cur) ? cur : cur + CTR_W'(1)) : ((|cur) ? cur - CTR_W'(1) : cur);
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int i = 0; i < (1 << IDX_W); i++) ctr[i] <= CTR_INIT;
      end else if (upd_valid) begin
         ctr[upd_idx] <= nxt;
      end
   // The lookup samples the table before this edge's update lands: read-before-write.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_idx   <= '0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_idx   <= idx;
            pred_taken <= ctr[idx][CTR_W-1];
         end
      end
endmodule

// File: tb/tb_branch_predictor_pht.sv
// tb_branch_predictor_pht: scoreboard bench driving a CTR_W=2 and a CTR_W=3 PHT with shared stimulus.
module tb_branch_predictor_pht;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        lookup_valid = 1'b0;
   logic [31:0] lookup_pc = '0;
   logic        upd_valid = 1'b0;
   logic [3:0]  upd_idx = '0;
   logic        upd_taken = 1'b0;
   logic        ghr_clr = 1'b0;
   logic        pred_valid, pred_taken, pred_valid3, pred_taken3;
   logic [3:0]  pred_idx, pred_idx3, ghr, ghr3;
   int          errors = 0;
   int          checks = 0;
   int          m2 [16];
   int          m3 [16];
   logic [3:0]  mghr = '0;
`ifdef BP_GSHARE_EN
   localparam bit GS = 1'b1;
`else
   localparam bit GS = 1'b0;
`endif
   typedef struct packed {logic t2; logic t3; logic [3:0] idx;} exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   branch_predictor_pht #(.PC_W(32), .IDX_W(4), .CTR_W(2), .GHR_W(4)) u_dut (
      .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .ghr_clr(ghr_clr), .ghr(ghr));

   branch_predictor_pht #(.PC_W(32), .IDX_W(4), .CTR_W(3), .GHR_W(4)) u_dut3 (
      .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(pred_valid3), .pred_taken(pred_taken3), .pred_idx(pred_idx3),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .ghr_clr(ghr_clr), .ghr(ghr3));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] pc_for(input logic [3:0] k);
      return {26'b0, k ^ mghr, 2'b00};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m2[i] = 1;
         m3[i] = 3;
      end
      mghr = '0;
      q.delete();
   endtask

   task automatic cycle(input logic lv, input logic [31:0] pc, input logic uv,
                        input logic [3:0] ui, input logic ut, input logic gc);
      exp_t e;
      @(negedge clk);
      lookup_valid = lv; lookup_pc = pc; upd_valid = uv; upd_idx = ui; upd_taken = ut; ghr_clr = gc;
      if (lv) begin
         e.idx = pc[5:2] ^ mghr;
         e.t2  = m2[e.idx] >= 2;
         e.t3  = m3[e.idx] >= 4;
         q.push_back(e);
      end
      if (uv) begin
         m2[ui] = ut ? (m2[ui] < 3 ? m2[ui] + 1 : 3) : (m2[ui] > 0 ? m2[ui] - 1 : 0);
         m3[ui] = ut ? (m3[ui] < 7 ? m3[ui] + 1 : 7) : (m3[ui] > 0 ? m3[ui] - 1 : 0);
      end
      if (GS) mghr = gc ? 4'd0 : (uv ? {mghr[2:0], ut} : mghr);
      @(posedge clk);
      #1;
      check("pred_valid", pred_valid, q.size() != 0);
      check("pred_valid3", pred_valid3, q.size() != 0);
      check("ghr", ghr, mghr);
      if (q.size() != 0) begin
         e = q.pop_front();
         check("pred_taken", pred_taken, e.t2);
         check("pred_taken3", pred_taken3, e.t3);
         check("pred_idx", pred_idx, e.idx);
         check("pred_idx3", pred_idx3, e.idx);
      end
   endtask

   task automatic idle();
      cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic upd(input logic [3:0] ui, input logic ut);
      cycle(1'b0, 32'd0, 1'b1, ui, ut, 1'b0);
   endtask

   task automatic look(input logic [3:0] k);
      cycle(1'b1, pc_for(k), 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pred_valid", pred_valid, 0);
      check("rst_pred_taken", pred_taken, 0);
      check("rst_pred_idx", pred_idx, 0);
      check("rst_ghr", ghr, 0);
      for (int i = 0; i < 16; i++) begin
         check("rst_ctr2", u_dut.ctr[i], 32'd1);
         check("rst_ctr3", u_dut3.ctr[i], 32'd3);
      end
      @(negedge clk);
      reset = 1'b1;

      cycle(1'b1, 32'h40, 1'b0, 4'd0, 1'b0, 1'b0);
      check("first_idx", pred_idx, 0);
      check("first_taken", pred_taken, 0);

      repeat (3) upd(4'd5, 1'b1);
      check("ctr5_sat_hi", u_dut.ctr[5], 32'd3);
      look(4'd5);
      check("idx5_taken", pred_taken, 1);
      repeat (4) upd(4'd5, 1'b0);
      check("ctr5_sat_lo", u_dut.ctr[5], 32'd0);
      look(4'd5);
      check("idx5_not_taken", pred_taken, 0);

      repeat (5) upd(4'd7, 1'b1);
      check("ctr3_sat_hi", u_dut3.ctr[7], 32'd7);
      repeat (8) upd(4'd7, 1'b0);
      check("ctr3_sat_lo", u_dut3.ctr[7], 32'd0);

      cycle(1'b1, pc_for(4'd3), 1'b1, 4'd3, 1'b1, 1'b0);
      check("rbw_old", pred_taken, 0);
      look(4'd3);
      check("rbw_new", pred_taken, 1);

      cycle(1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      upd(4'd9, 1'b1);
      upd(4'd9, 1'b0);
      upd(4'd9, 1'b1);
      upd(4'd9, 1'b1);
      check("ghr_tntt", ghr, GS ? 32'hB : 32'h0);
      cycle(1'b1, 32'h0C, 1'b0, 4'd0, 1'b0, 1'b0);
      check("idx_pc0c", pred_idx, GS ? 32'h8 : 32'h3);
      cycle(1'b0, 32'd0, 1'b1, 4'd2, 1'b1, 1'b1);
      check("ghr_clr_prio", ghr, 0);
      check("clr_ctr_upd", u_dut.ctr[2], 32'd2);

      for (int n = 0; n < 200; n++)
         cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);

      repeat (3) upd(4'd10, 1'b1);
      look(4'd10);
      check("pre_rst_taken", pred_taken, 1);
      @(negedge clk);
      lookup_valid = 1'b1;
      lookup_pc = pc_for(4'd10);
      upd_valid = 1'b0;
      ghr_clr = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_valid", pred_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_valid", pred_valid, 0);
      check("async_taken", pred_taken, 0);
      check("async_idx", pred_idx, 0);
      check("async_valid3", pred_valid3, 0);
      check("async_ghr", ghr, 0);
      for (int i = 0; i < 16; i++) begin
         check("async_ctr2", u_dut.ctr[i], 32'd1);
         check("async_ctr3", u_dut3.ctr[i], 32'd3);
      end
      model_reset();
      @(negedge clk);
      lookup_valid = 1'b0;
      reset = 1'b1;
      idle();
      look(4'd10);
      check("post_rst_taken", pred_taken, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/branch_predictor_pht.md
Name: branch_predictor_pht

Overview:
- Parametrised pattern history table (PHT) branch predictor: 2^IDX_W saturating counters of CTR_W bits each, plus a global history register (GHR).
- Successor to the single-context 2-bit counter; it adds width and depth parameters, indexed contexts, registered prediction with index tag-back, and optional gshare hashing.
- Sits beside the fetch stage. Fetch issues a lookup each cycle; the execute/branch-resolve stage returns the outcome with the index it was predicted from.

Parameters:
- PC_W, 32, width of the program counter.
- IDX_W, 6, PHT index width; the table has 2^IDX_W entries.
- CTR_W, 2, counter width; legal range 2..4.
- GHR_W, 6, global history length; must be <= IDX_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  fetch requests a prediction this cycle.
- lookup_pc  in  PC_W  PC of the fetched branch.
- pred_valid  out  1  registered; high one cycle after lookup_valid.
- pred_taken  out  1  registered prediction: MSB of the selected counter.
- pred_idx  out  IDX_W  registered index used; carried down the pipe to the update port.
- upd_valid  in  1  resolved-branch update strobe.
- upd_idx  in  IDX_W  index returned from pred_idx.
- upd_taken  in  1  actual branch outcome.
- ghr_clr  in  1  synchronous clear of the GHR (e.g. context switch).
- ghr  out  GHR_W  current global history.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every counter is loaded with 2^(CTR_W-1)-1, weakly not-taken (01 for CTR_W=2).
  - GHR is cleared to 0.
  - pred_valid, pred_taken and pred_idx are 0.
- Index computation is combinational from lookup_pc. Bits [1:0] are ignored (word-aligned instructions).
  - Bimodal: idx = lookup_pc[IDX_W+1:2].
  - Gshare: idx = lookup_pc[IDX_W+1:2] XOR {zero-extend GHR to IDX_W}.
- Lookup latency is 1 cycle:
  - pred_valid <= lookup_valid.
  - When lookup_valid=1: pred_idx <= idx and pred_taken <= counter[idx][CTR_W-1].
  - When lookup_valid=0: pred_valid=0, and pred_taken/pred_idx hold their last values.
- Update, on upd_valid=1:
  - If upd_taken=1: counter[upd_idx] increments, saturating at 2^CTR_W-1.
  - If upd_taken=0: counter[upd_idx] decrements, saturating at 0.
  - No wrap-around in either direction.
- GHR update, on upd_valid=1: GHR <= {GHR[GHR_W-2:0], upd_taken}. The GHR is non-speculative and updated only at resolve.
- Simultaneous lookup and update:
  - Same entry: the lookup reads the pre-update counter value (read-before-write); the update still commits.
  - Different entries: both proceed independently.
- Lookup in the same cycle as a GHR change: the index uses the GHR value before the edge.
- ghr_clr=1: GHR <= 0 next edge and takes priority over a simultaneous upd_valid shift. The counter update for that upd_valid still occurs.
- Counters are not cleared by ghr_clr; only reset clears them.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight prediction is discarded (pred_valid=0).
- Only one update per cycle. An upd_idx outside the table is impossible by width.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined: gshare index as above; GHR is maintained and driven on the ghr port; ghr_clr is functional.
- Undefined: bimodal index only; GHR register is not instantiated; ghr output is tied to 0; ghr_clr is ignored.

Test Plan (IDX_W=4, CTR_W=2, GHR_W=4 unless noted):
- Reset, then lookup_valid=1 with lookup_pc=0x40 → next cycle pred_valid=1, pred_taken=0, pred_idx=0x0. A dump of all 16 counters reads 01.
- Three updates upd_idx=5, upd_taken=1 → counter 5 goes 01→10→11→11 (saturates). A subsequent lookup mapping to index 5 gives pred_taken=1. Four not-taken updates then give 00 (saturates at 0).
- Same-cycle lookup and update on index 3 (counter=01, upd_taken=1) → pred_taken=0 (old value); the next lookup of index 3 gives pred_taken=1.
- BP_GSHARE_EN defined:
  - Updates with outcomes T,N,T,T → ghr=4'b1011.
  - Lookup_pc=0x0C (base idx 3) → pred_idx=3 XOR 0xB = 0x8.
  - ghr_clr together with upd_valid → ghr=0.
- BP_GSHARE_EN undefined → ghr stays 0 after any updates; lookup_pc=0x0C gives pred_idx=0x3.
- Assert reset mid-stream with counters trained and pred_valid=1 → outputs drop to 0 asynchronously and all counters return to 01. CTR_W=3 rerun: reset value is 011, saturation limits are 000/111.
